// File: rtl/mem_arbiter.sv
// Arbitrates the fetch port and the data port onto one single-ported memory, one access at a time.
// Optional macro ARB_RR_EN: a tie in IDLE goes to the port that was not granted last.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err,
  output logic [1:0]        state_dbg
);

  // Handshakes: a requester raises x_req with a stable payload and keeps it until x_done
  // pulses for one cycle. Towards memory, mem_req and its payload stay put until a
  // one-cycle mem_ack (or the timeout); mem_ack outside an access is ignored.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              mem_req_n, mem_we_n, if_done_n, dm_done_n, err_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, if_rdata_n, dm_rdata_n;
  logic              grant_dm;
`ifdef ARB_RR_EN
  logic              last_dm, last_dm_n;
`endif

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
`ifdef ARB_RR_EN
    // On a tie, alternate away from whoever won last time.
    grant_dm = dm_req && (!if_req || !last_dm);
`else
    grant_dm = dm_req;
`endif
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if_rdata_n  = if_rdata;
    dm_rdata_n  = dm_rdata;
    if_done_n   = 1'b0;
    dm_done_n   = 1'b0;
    err_n       = 1'b0;
`ifdef ARB_RR_EN
    last_dm_n   = last_dm;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (grant_dm) begin
          state_n     = DM_ACC;
          mem_req_n   = 1'b1;
          mem_we_n    = dm_we;
          mem_addr_n  = dm_addr;
          mem_wdata_n = dm_wdata;
`ifdef ARB_RR_EN
          last_dm_n   = 1'b1;
`endif
        end else if (if_req) begin
          state_n     = IF_ACC;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b0;
          mem_addr_n  = if_addr;
          mem_wdata_n = '0;
`ifdef ARB_RR_EN
          last_dm_n   = 1'b0;
`endif
        end
      end
      IF_ACC, DM_ACC: begin
        cnt_n = cnt + CNT_W'(1);
        // An ack arriving on the last allowed cycle still counts as a normal completion.
        if (mem_ack || (cnt == CNT_LAST)) begin
          state_n   = RESP;
          mem_req_n = 1'b0;
          err_n     = !mem_ack;
          if (state == DM_ACC) begin
            dm_done_n = 1'b1;
            if (!mem_we) dm_rdata_n = mem_ack ? mem_rdata : '0;
          end else begin
            if_done_n  = 1'b1;
            if_rdata_n = mem_ack ? mem_rdata : '0;
          end
        end
      end
      RESP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      err       <= 1'b0;
`ifdef ARB_RR_EN
      last_dm   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_rdata  <= if_rdata_n;
      dm_rdata  <= dm_rdata_n;
      if_done   <= if_done_n;
      dm_done   <= dm_done_n;
      err       <= err_n;
`ifdef ARB_RR_EN
      last_dm   <= last_dm_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected completions are queued at stimulus time and
// popped by a monitor whenever if_done/dm_done pulses.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          busy;
  logic          err;
  logic [1:0]    state_dbg;

  int checks = 0;
  int failures = 0;

  // Scoreboard entries: {is_write, err, rdata}
  logic [DW+1:0] if_exp_q[$];
  logic [DW+1:0] dm_exp_q[$];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dm_drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
  endtask

  task automatic ack_set(input logic [DW-1:0] d);
    mem_ack = 1'b1; mem_rdata = d;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [DW+1:0] e;
  always @(negedge clk) begin
    if (rst) begin
      chk("done_exclusive", {62'd0, if_done, dm_done} == 64'd3, 64'd0);
      if (if_done) begin
        chk("if_unexpected_done", if_exp_q.size() == 0, 64'd0);
        if (if_exp_q.size() != 0) begin
          e = if_exp_q.pop_front();
          chk("if_err", err, e[DW]);
          chk("if_rdata", if_rdata, e[DW-1:0]);
        end
      end
      if (dm_done) begin
        chk("dm_unexpected_done", dm_exp_q.size() == 0, 64'd0);
        if (dm_exp_q.size() != 0) begin
          e = dm_exp_q.pop_front();
          chk("dm_err", err, e[DW]);
          if (!e[DW+1]) chk("dm_rdata", dm_rdata, e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [AW-1:0] first_addr, second_addr;

  initial begin
    // Reset state
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {if_done, dm_done, err}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    chk("rst_state", state_dbg, 0);
    tick();
    rst = 1'b1;
    tick();

    // IF read of 0x10, ack one cycle after mem_req rises
    if_req = 1'b1; if_addr = 32'h10;
    if_exp_q.push_back({2'b00, 32'hDEADBEEF});
    tick();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_busy", busy, 1);
    ack_set(32'hDEADBEEF); if_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    chk("t1_if_done", if_done, 1);
    chk("t1_mem_req_low", mem_req, 0);
    tick();
    chk("t1_if_done_pulse", if_done, 0);
    chk("t1_busy_idle", busy, 0);

    // Tie: DM write 0x20<-0x55 against IF 0x0; DM first, IF after one bubble
    dm_drive(1'b1, 32'h20, 32'h55);
    if_req = 1'b1; if_addr = 32'h0;
    dm_exp_q.push_back({2'b10, 32'h0});
    if_exp_q.push_back({2'b00, 32'h1234});
    tick();
    chk("t2_state_dm", state_dbg, 2);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_wdata", mem_wdata, 32'h55);
    chk("t2_mem_addr", mem_addr, 32'h20);
    ack_set(32'hFFFF_FFFF); dm_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    chk("t2_dm_done", dm_done, 1);
    tick();
    chk("t2_bubble", {mem_req, busy}, 0);
    tick();
    chk("t2_if_grant_addr", mem_addr, 32'h0);
    chk("t2_if_grant_we", {mem_req, mem_we}, 2'b10);
    ack_set(32'h1234); if_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    tick();

    // Repeated tie with both requests held across a DM completion
    dm_drive(1'b0, 32'h24, 32'h0);
    if_req = 1'b1; if_addr = 32'h4;
    dm_exp_q.push_back({2'b00, 32'hA0});
    if (RR) begin
      if_exp_q.push_back({2'b00, 32'hB0});
      dm_exp_q.push_back({2'b00, 32'hC0});
    end else begin
      dm_exp_q.push_back({2'b00, 32'hB0});
      if_exp_q.push_back({2'b00, 32'hC0});
    end
    first_addr  = RR ? 32'h4 : 32'h28;
    second_addr = RR ? 32'h28 : 32'h4;
    tick();
    chk("t3_dm_first", mem_addr, 32'h24);
    ack_set(32'hA0);
    tick();
    mem_ack = 1'b0;
    dm_addr = 32'h28;
    tick();
    chk("t3_bubble", busy, 0);
    tick();
    chk("t3_repeat_winner", mem_addr, first_addr);
    ack_set(32'hB0);
    if (RR) if_req = 1'b0; else dm_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    chk("t3_loser_served", mem_addr, second_addr);
    chk("t3_loser_req", mem_req, 1);
    ack_set(32'hC0);
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    tick();

    // Timeout with WAIT_MAX=4: mem_req for exactly 4 cycles, then done+err, rdata 0
    dm_drive(1'b0, 32'h30, 32'h0);
    dm_exp_q.push_back({2'b01, 32'h0});
    tick();
    dm_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_mem_req_held", mem_req, 1);
      tick();
    end
    chk("t4_mem_req_dropped", mem_req, 0);
    chk("t4_done_err", {dm_done, err}, 2'b11);
    tick();
    chk("t4_after", {busy, err, dm_done}, 0);

    // Ack on the timeout cycle wins: normal completion
    dm_drive(1'b0, 32'h34, 32'h0);
    dm_exp_q.push_back({2'b00, 32'h77});
    tick();
    dm_req = 1'b0;
    tick(); tick(); tick();
    ack_set(32'h77);
    tick();
    mem_ack = 1'b0;
    chk("t5_done_no_err", {dm_done, err}, 2'b10);
    tick();

    // Reset during DM_ACC: outputs drop at once, late ack ignored
    dm_drive(1'b0, 32'h40, 32'h0);
    tick();
    chk("t6_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("t6_mem_req_rst", mem_req, 0);
    chk("t6_busy_rst", busy, 0);
    dm_req = 1'b0;
    tick();
    rst = 1'b1;
    ack_set(32'h99);
    tick();
    mem_ack = 1'b0;
    chk("t6_late_ack", {busy, dm_done}, 0);
    tick();
    chk("t6_still_idle", {busy, dm_done, dm_rdata}, 0);

    // dm_req held across done, 2-cycle ack, then dropped mid-access
    dm_drive(1'b0, 32'h50, 32'h0);
    dm_exp_q.push_back({2'b00, 32'h11});
    dm_exp_q.push_back({2'b00, 32'h22});
    tick();
    tick();
    ack_set(32'h11);
    tick();
    mem_ack = 1'b0;
    chk("t7_first_done", dm_done, 1);
    dm_addr = 32'h54;
    tick();
    chk("t7_bubble", {busy, mem_req}, 0);
    tick();
    chk("t7_second_grant", mem_addr, 32'h54);
    dm_req = 1'b0;
    tick();
    ack_set(32'h22);
    tick();
    mem_ack = 1'b0;
    chk("t7_dropped_done", dm_done, 1);
    tick();
    tick();
    chk("t7_no_new_access", busy, 0);

    tick(); tick();
    chk("sb_if_empty", if_exp_q.size(), 0);
    chk("sb_dm_empty", dm_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
